id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register with built-in hazard detection.
- Captures decoded instruction fields from the ID stage and presents the registered ID_EX_* fields to EX and to the forwarding unit, which forwards only from MEM/WB.
- Because there is no EX/MEM forwarding path, the block inserts exactly one bubble when the instruction in ID depends on the producer currently held in ID/EX.
- Also handles branch flush and global hold, and keeps a saturating stall counter.

Parameters:
- XLEN, 32, data/PC width
- CTRL_W, 9, control bundle width; bit0=RegWrite, bit1=MemRead, remaining bits opaque pass-through
- CNT_W, 16, stall counter width

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- hold  input  1  global freeze (memory busy)
- flush  input  1  branch taken in EX; kill instruction in ID
- if_id_valid  input  1  ID holds a real instruction
- if_id_pc  input  XLEN  PC of ID instruction
- if_id_rs1, if_id_rs2, if_id_rd  input  5 each  register indices
- if_id_uses_rs1, if_id_uses_rs2  input  1 each  operand actually read
- if_id_rs1_data, if_id_rs2_data, if_id_imm  input  XLEN each  operands / immediate
- if_id_ctrl  input  CTRL_W  decoded control
- ID_EX_valid  output  1  registered valid
- ID_EX_pc, ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm  output  XLEN each  registered fields
- ID_EX_RegisterRs1, ID_EX_RegisterRs2, ID_EX_RegisterRd  output  5 each  registered indices (to forwarding unit)
- ID_EX_ctrl  output  CTRL_W  registered control
- stall  output  1  load/ALU-use bubble inserted this cycle
- pc_write, if_id_write  output  1 each  enable PC and IF/ID update (combinational)
- stall_count  output  CNT_W  saturating count of bubble cycles

Behaviour:
- Reset (rst_n=0, async): all ID_EX_* outputs = 0, ID_EX_valid=0, stall_count=0. pc_write/if_id_write follow the combinational equations below, which give 1 with the registered state at reset.
- Dependency (combinational): dep = ID_EX_valid & ID_EX_ctrl[0] & (ID_EX_RegisterRd!=0) & if_id_valid & ((if_id_uses_rs1 & if_id_rs1==ID_EX_RegisterRd) | (if_id_uses_rs2 & if_id_rs2==ID_EX_RegisterRd)).
  - Applies to every producer type, loads included.
- stall = dep & ~flush & ~hold.
- pc_write = if_id_write = ~hold & ~stall.
- Per rising edge, priority order:
  1. hold=1: all registers keep their value; stall_count unchanged.
  2. flush=1: load bubble. A flush overrides any stall.
  3. stall=1: load bubble; stall_count += 1, saturating at all-ones.
  4. Otherwise: capture all if_id_* fields into ID_EX_*; ID_EX_valid = if_id_valid.
- Bubble: ID_EX_valid=0, ctrl=0, Rs1=Rs2=Rd=0, pc/data/imm=0. Zero register indices guarantee no spurious forwarding.
- An instruction with if_id_valid=0 is captured as-is. Its ctrl is forced to 0 so RegWrite cannot leak.
- Latency: 1 cycle ID to EX in the normal case; exactly +1 cycle per dependency.
- Back-to-back stalls: after a bubble, ID_EX_valid=0, so dep=0 next cycle. At most one consecutive bubble per instruction.
- rd=x0 producers never stall.
- Assertion of rst_n mid-stall clears the stall immediately and asynchronously.

Test Plan:
- Reset:
  - Assert rst_n=0 mid-stream → all ID_EX_* = 0, stall_count=0, stall=0, pc_write=1 asynchronously.
- RAW on rs1:
  - ID/EX holds add rd=5, RegWrite=1. ID has sub rs1=5, uses_rs1=1.
  - → stall=1, pc_write=0, next ID_EX_valid=0 with Rd=0.
  - Following cycle the sub is captured, ID_EX_RegisterRs1=5, stall_count=1.
- No false stall:
  - ID/EX addi rd=5. ID is addi rs1=3, rs2 field=5, uses_rs2=0 → stall=0, captured next edge.
  - Repeat with rd=0 and matching rs1 → stall=0.
- Flush beats stall:
  - dep true and flush=1 → stall=0, pc_write=1, bubble loaded, stall_count unchanged.
- Hold:
  - hold=1 for 3 cycles with changing inputs → ID_EX_* frozen, pc_write=0, stall=0.
  - Release hold → normal capture.
- Counter saturation:
  - CNT_W=2, force 5 dependency stalls → stall_count sequence 1,2,3,3,3.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with RAW hazard detection against the instruction held in ID/EX.
// Forwarding exists only from MEM/WB, so a dependent instruction in ID costs exactly one bubble.
module id_ex_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CTRL_W = 9,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              flush,
  input  logic              if_id_valid,
  input  logic [XLEN-1:0]   if_id_pc,
  input  logic [4:0]        if_id_rs1,
  input  logic [4:0]        if_id_rs2,
  input  logic [4:0]        if_id_rd,
  input  logic              if_id_uses_rs1,
  input  logic              if_id_uses_rs2,
  input  logic [XLEN-1:0]   if_id_rs1_data,
  input  logic [XLEN-1:0]   if_id_rs2_data,
  input  logic [XLEN-1:0]   if_id_imm,
  input  logic [CTRL_W-1:0] if_id_ctrl,
  output logic              ID_EX_valid,
  output logic [XLEN-1:0]   ID_EX_pc,
  output logic [XLEN-1:0]   ID_EX_rs1_data,
  output logic [XLEN-1:0]   ID_EX_rs2_data,
  output logic [XLEN-1:0]   ID_EX_imm,
  output logic [4:0]        ID_EX_RegisterRs1,
  output logic [4:0]        ID_EX_RegisterRs2,
  output logic [4:0]        ID_EX_RegisterRd,
  output logic [CTRL_W-1:0] ID_EX_ctrl,
  output logic              stall,
  output logic              pc_write,
  output logic              if_id_write,
  output logic [CNT_W-1:0]  stall_count
);

  logic rs1_hit;
  logic rs2_hit;
  logic producer_live;
  logic dep;
  logic bubble;

  // A bubble in ID/EX has valid=0 and rd=0, so it can never cause a second consecutive stall.
  always_comb begin
    rs1_hit       = if_id_uses_rs1 && (if_id_rs1 == ID_EX_RegisterRd);
    rs2_hit       = if_id_uses_rs2 && (if_id_rs2 == ID_EX_RegisterRd);
    producer_live = ID_EX_valid && ID_EX_ctrl[0] && (ID_EX_RegisterRd != 5'd0);
    dep           = producer_live && if_id_valid && (rs1_hit || rs2_hit);
  end

  assign stall       = dep & ~flush & ~hold;
  assign pc_write    = ~hold & ~stall;
  assign if_id_write = ~hold & ~stall;
  assign bubble      = flush | stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ID_EX_valid       <= 1'b0;
      ID_EX_pc          <= '0;
      ID_EX_rs1_data    <= '0;
      ID_EX_rs2_data    <= '0;
      ID_EX_imm         <= '0;
      ID_EX_RegisterRs1 <= '0;
      ID_EX_RegisterRs2 <= '0;
      ID_EX_RegisterRd  <= '0;
      ID_EX_ctrl        <= '0;
    end else if (!hold) begin
      if (bubble) begin
        ID_EX_valid       <= 1'b0;
        ID_EX_pc          <= '0;
        ID_EX_rs1_data    <= '0;
        ID_EX_rs2_data    <= '0;
        ID_EX_imm         <= '0;
        ID_EX_RegisterRs1 <= '0;
        ID_EX_RegisterRs2 <= '0;
        ID_EX_RegisterRd  <= '0;
        ID_EX_ctrl        <= '0;
      end else begin
        ID_EX_valid       <= if_id_valid;
        ID_EX_pc          <= if_id_pc;
        ID_EX_rs1_data    <= if_id_rs1_data;
        ID_EX_rs2_data    <= if_id_rs2_data;
        ID_EX_imm         <= if_id_imm;
        ID_EX_RegisterRs1 <= if_id_rs1;
        ID_EX_RegisterRs2 <= if_id_rs2;
        ID_EX_RegisterRd  <= if_id_rd;
        // Invalid slots keep their fields but must not carry RegWrite/MemRead downstream.
        ID_EX_ctrl        <= if_id_valid ? if_id_ctrl : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

  a_stall_bubbles : assert property (@(posedge clk) disable iff (!rst_n)
    stall |=> !ID_EX_valid);

  a_hold_freezes : assert property (@(posedge clk) disable iff (!rst_n)
    hold |=> $stable(ID_EX_pc) && $stable(ID_EX_ctrl) && $stable(stall_count));

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: the driver queues expected responses, monitors pop and compare.
module tb_id_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        hold;
  logic        flush;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [4:0]  if_id_rs1;
  logic [4:0]  if_id_rs2;
  logic [4:0]  if_id_rd;
  logic        if_id_uses_rs1;
  logic        if_id_uses_rs2;
  logic [31:0] if_id_rs1_data;
  logic [31:0] if_id_rs2_data;
  logic [31:0] if_id_imm;
  logic [8:0]  if_id_ctrl;
  logic        ID_EX_valid;
  logic [31:0] ID_EX_pc;
  logic [31:0] ID_EX_rs1_data;
  logic [31:0] ID_EX_rs2_data;
  logic [31:0] ID_EX_imm;
  logic [4:0]  ID_EX_RegisterRs1;
  logic [4:0]  ID_EX_RegisterRs2;
  logic [4:0]  ID_EX_RegisterRd;
  logic [8:0]  ID_EX_ctrl;
  logic        stall;
  logic        pc_write;
  logic        if_id_write;
  logic [1:0]  stall_count;

  id_ex_stage #(.XLEN(32), .CTRL_W(9), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush),
    .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .if_id_rd(if_id_rd),
    .if_id_uses_rs1(if_id_uses_rs1), .if_id_uses_rs2(if_id_uses_rs2),
    .if_id_rs1_data(if_id_rs1_data), .if_id_rs2_data(if_id_rs2_data),
    .if_id_imm(if_id_imm), .if_id_ctrl(if_id_ctrl),
    .ID_EX_valid(ID_EX_valid), .ID_EX_pc(ID_EX_pc),
    .ID_EX_rs1_data(ID_EX_rs1_data), .ID_EX_rs2_data(ID_EX_rs2_data),
    .ID_EX_imm(ID_EX_imm), .ID_EX_RegisterRs1(ID_EX_RegisterRs1),
    .ID_EX_RegisterRs2(ID_EX_RegisterRs2), .ID_EX_RegisterRd(ID_EX_RegisterRd),
    .ID_EX_ctrl(ID_EX_ctrl), .stall(stall), .pc_write(pc_write),
    .if_id_write(if_id_write), .stall_count(stall_count)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [8:0]  ctrl;
    logic [1:0]  cnt;
  } exp_r_t;

  typedef struct packed {
    logic stall;
    logic pcw;
  } exp_c_t;

  localparam int CAP  = 0;
  localparam int BUB  = 1;
  localparam int HOLD = 2;

  exp_r_t rq[$];
  exp_c_t cq[$];
  exp_r_t last_r;
  int n_chk;
  int n_fail;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Combinational outputs are sampled mid-cycle, with the cycle's inputs settled.
  always @(negedge clk) begin
    if (cq.size() > 0) begin
      exp_c_t c;
      c = cq.pop_front();
      chk("stall", 32'(stall), 32'(c.stall));
      chk("pc_write", 32'(pc_write), 32'(c.pcw));
      chk("if_id_write", 32'(if_id_write), 32'(c.pcw));
    end
  end

  // Registered outputs are sampled just after the edge, before the driver moves inputs.
  always @(posedge clk) begin
    #1;
    if (rq.size() > 0) begin
      exp_r_t r;
      r = rq.pop_front();
      chk("valid", 32'(ID_EX_valid), 32'(r.valid));
      chk("pc", ID_EX_pc, r.pc);
      chk("rs1_data", ID_EX_rs1_data, r.d1);
      chk("rs2_data", ID_EX_rs2_data, r.d2);
      chk("imm", ID_EX_imm, r.imm);
      chk("rs1", 32'(ID_EX_RegisterRs1), 32'(r.rs1));
      chk("rs2", 32'(ID_EX_RegisterRs2), 32'(r.rs2));
      chk("rd", 32'(ID_EX_RegisterRd), 32'(r.rd));
      chk("ctrl", 32'(ID_EX_ctrl), 32'(r.ctrl));
      chk("stall_count", 32'(stall_count), 32'(r.cnt));
    end
  end

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input logic u1,
                        input logic u2, input logic [8:0] ctrl);
    if_id_valid    = v;
    if_id_pc       = pc;
    if_id_rs1      = rs1;
    if_id_rs2      = rs2;
    if_id_rd       = rd;
    if_id_uses_rs1 = u1;
    if_id_uses_rs2 = u2;
    if_id_rs1_data = {pc[15:0], 16'h1111};
    if_id_rs2_data = {pc[15:0], 16'h2222};
    if_id_imm      = {16'h0, pc[15:0]} ^ 32'h0000_0F0F;
    if_id_ctrl     = ctrl;
  endtask

  // One clock of stimulus: drive ID, queue expected stall/pc_write and the post-edge ID/EX state.
  task automatic cyc(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [4:0] rd, input logic u1,
                     input logic u2, input logic [8:0] ctrl, input logic h, input logic f,
                     input logic es, input logic epcw, input int kind, input logic [1:0] ecnt);
    exp_r_t r;
    set_id(v, pc, rs1, rs2, rd, u1, u2, ctrl);
    hold  = h;
    flush = f;
    cq.push_back('{stall: es, pcw: epcw});
    if (kind == CAP) begin
      r.valid = v;
      r.pc    = pc;
      r.d1    = {pc[15:0], 16'h1111};
      r.d2    = {pc[15:0], 16'h2222};
      r.imm   = {16'h0, pc[15:0]} ^ 32'h0000_0F0F;
      r.rs1   = rs1;
      r.rs2   = rs2;
      r.rd    = rd;
      r.ctrl  = v ? ctrl : 9'h000;
      r.cnt   = ecnt;
    end else if (kind == BUB) begin
      r     = '0;
      r.cnt = ecnt;
    end else begin
      r = last_r;
    end
    last_r = r;
    rq.push_back(r);
    @(posedge clk);
    #2;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    last_r = '0;
    rst_n  = 1'b0;
    hold   = 1'b0;
    flush  = 1'b0;
    set_id(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 9'h000);
    #2;
    chk("reset_valid", 32'(ID_EX_valid), 32'd0);
    chk("reset_pc", ID_EX_pc, 32'd0);
    chk("reset_count", 32'(stall_count), 32'd0);
    chk("reset_pc_write", 32'(pc_write), 32'd1);
    #6;
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    // RAW on rs1: add x5 in ID/EX, sub reads x5 -> one bubble, then captured
    cyc(1, 32'h100, 5'd1,  5'd2,  5'd5,  1, 1, 9'h001, 0, 0, 0, 1, CAP, 2'd0);
    cyc(1, 32'h104, 5'd5,  5'd6,  5'd7,  1, 1, 9'h001, 0, 0, 1, 0, BUB, 2'd1);
    cyc(1, 32'h104, 5'd5,  5'd6,  5'd7,  1, 1, 9'h001, 0, 0, 0, 1, CAP, 2'd1);
    // No false stalls: unused rs2 match, rd=x0 producer, invalid consumer / producer
    cyc(1, 32'h108, 5'd0,  5'd0,  5'd5,  1, 0, 9'h001, 0, 0, 0, 1, CAP, 2'd1);
    cyc(1, 32'h10C, 5'd3,  5'd5,  5'd8,  1, 0, 9'h001, 0, 0, 0, 1, CAP, 2'd1);
    cyc(1, 32'h110, 5'd1,  5'd0,  5'd0,  1, 0, 9'h001, 0, 0, 0, 1, CAP, 2'd1);
    cyc(1, 32'h114, 5'd0,  5'd0,  5'd9,  1, 1, 9'h001, 0, 0, 0, 1, CAP, 2'd1);
    cyc(0, 32'h118, 5'd9,  5'd0,  5'd10, 1, 0, 9'h1FF, 0, 0, 0, 1, CAP, 2'd1);
    cyc(1, 32'h11C, 5'd10, 5'd0,  5'd11, 1, 0, 9'h001, 0, 0, 0, 1, CAP, 2'd1);
    // Flush beats a live dependency: bubble, counter untouched
    cyc(1, 32'h120, 5'd11, 5'd0,  5'd12, 1, 0, 9'h001, 0, 1, 0, 1, BUB, 2'd1);
    cyc(1, 32'h124, 5'd1,  5'd0,  5'd12, 1, 0, 9'h003, 0, 0, 0, 1, CAP, 2'd1);
    // Hold for three cycles with changing inputs (one with dep, one with flush)
    cyc(1, 32'h128, 5'd12, 5'd0,  5'd13, 1, 0, 9'h001, 1, 0, 0, 0, HOLD, 2'd1);
    cyc(1, 32'h12C, 5'd2,  5'd12, 5'd14, 0, 1, 9'h005, 1, 0, 0, 0, HOLD, 2'd1);
    cyc(1, 32'h130, 5'd12, 5'd0,  5'd13, 1, 0, 9'h001, 1, 1, 0, 0, HOLD, 2'd1);
    cyc(1, 32'h134, 5'd3,  5'd4,  5'd15, 1, 1, 9'h001, 0, 0, 0, 1, CAP, 2'd1);
    // Counter saturation at CNT_W=2: stalls 2..5 give 2,3,3,3 (load producer included)
    cyc(1, 32'h138, 5'd0,  5'd15, 5'd16, 0, 1, 9'h001, 0, 0, 1, 0, BUB, 2'd2);
    cyc(1, 32'h138, 5'd0,  5'd15, 5'd16, 0, 1, 9'h001, 0, 0, 0, 1, CAP, 2'd2);
    cyc(1, 32'h13C, 5'd16, 5'd0,  5'd17, 1, 0, 9'h003, 0, 0, 1, 0, BUB, 2'd3);
    cyc(1, 32'h13C, 5'd16, 5'd0,  5'd17, 1, 0, 9'h003, 0, 0, 0, 1, CAP, 2'd3);
    cyc(1, 32'h140, 5'd17, 5'd0,  5'd18, 1, 0, 9'h001, 0, 0, 1, 0, BUB, 2'd3);
    cyc(1, 32'h140, 5'd17, 5'd0,  5'd18, 1, 0, 9'h001, 0, 0, 0, 1, CAP, 2'd3);
    cyc(1, 32'h144, 5'd0,  5'd18, 5'd19, 0, 1, 9'h001, 0, 0, 1, 0, BUB, 2'd3);
    cyc(1, 32'h144, 5'd0,  5'd18, 5'd19, 0, 1, 9'h001, 0, 0, 0, 1, CAP, 2'd3);

    // Asynchronous reset in the middle of a stall cycle
    set_id(1'b1, 32'h148, 5'd19, 5'd0, 5'd20, 1'b1, 1'b0, 9'h001);
    cq.push_back('{stall: 1'b1, pcw: 1'b0});
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(ID_EX_valid), 32'd0);
    chk("async_pc", ID_EX_pc, 32'd0);
    chk("async_rd", 32'(ID_EX_RegisterRd), 32'd0);
    chk("async_ctrl", 32'(ID_EX_ctrl), 32'd0);
    chk("async_count", 32'(stall_count), 32'd0);
    chk("async_stall", 32'(stall), 32'd0);
    chk("async_pc_write", 32'(pc_write), 32'd1);
    chk("async_if_id_write", 32'(if_id_write), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10 && (rq.size() > 0 || cq.size() > 0); i++) @(posedge clk);
    chk("scoreboard_drained", 32'(rq.size() + cq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
